// File: rtl/raster_scan_sequencer_pkg.sv
// Shared constants for the raster-scan sequencer and the predictive-coding datapath.
// The datapath's average mux decodes pred_sel with the same PRED_* codes.
package raster_scan_sequencer_pkg;

  localparam int IMG_W_DEF  = 512;
  localparam int IMG_H_DEF  = 512;
  localparam int ADDR_W_DEF = 19;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_F_CUR = 3'd1;
  localparam logic [2:0] ST_F_W   = 3'd2;
  localparam logic [2:0] ST_F_N   = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] PRED_NONE = 2'd0;
  localparam logic [1:0] PRED_W    = 2'd1;
  localparam logic [1:0] PRED_N    = 2'd2;
  localparam logic [1:0] PRED_AVG  = 2'd3;

  // Counter width able to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_scan_sequencer_counter.sv
// Column/row/linear-address tracker for the raster walk.
// Flags are decoded straight from the registers so the FSM sees them in the same cycle.
module raster_counter
  import raster_scan_sequencer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              first_col,
  output logic              first_row,
  output logic              last_pixel
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      cur_addr <= '0;
    end else if (clear) begin
      col      <= '0;
      row      <= '0;
      cur_addr <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
      cur_addr <= cur_addr + ADDR_W'(1);
    end
  end

  assign first_col  = (col == '0);
  assign first_row  = (row == '0);
  assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/raster_scan_sequencer.sv
// Walks one image in raster order: fetch current/West/North pixels, then hand
// the prediction mode to the Huffman stage and hold until it is accepted.
//
// state  | meaning
// IDLE   | waiting for start after reset
// F_CUR  | read current pixel into R1
// F_W    | read West neighbour into R2
// F_N    | read North neighbour into R3
// EMIT   | err_valid high, waiting for err_ready
// DONE   | frame complete, waiting for start
module raster_scan_sequencer
  import raster_scan_sequencer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              load_cur,
  output logic              load_w,
  output logic              load_n,
  output logic [1:0]        pred_sel,
  output logic              err_valid,
  input  logic              err_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_count
);

  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W + 1)'(IMG_W * IMG_H);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              first_col;
  logic              first_row;
  logic              last_pixel;
  logic              start_ok;
  logic              accept;
  logic              advance;

  assign start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign accept   = (state == ST_EMIT) && err_ready;
  assign advance  = accept && !last_pixel;

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .advance    (advance),
    .cur_addr   (cur_addr),
    .first_col  (first_col),
    .first_row  (first_row),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_F_CUR;
      ST_F_CUR: begin
        if (!first_col)      state_nxt = ST_F_W;
        else if (!first_row) state_nxt = ST_F_N;
        else                 state_nxt = ST_EMIT;
      end
      ST_F_W:  state_nxt = first_row ? ST_EMIT : ST_F_N;
      ST_F_N:  state_nxt = ST_EMIT;
      ST_EMIT: if (err_ready) state_nxt = last_pixel ? ST_DONE : ST_F_CUR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Memory is combinational, so the fetch address is driven in the load cycle
  // itself; the register only keeps the last address stable between fetches.
  always_comb begin
    rd_addr = rd_addr_q;
    case (state)
      ST_F_CUR: rd_addr = cur_addr;
      ST_F_W:   rd_addr = cur_addr - ADDR_W'(1);
      ST_F_N:   rd_addr = cur_addr - ADDR_W'(IMG_W);
      default:  rd_addr = rd_addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_addr_q <= '0;
    else      rd_addr_q <= rd_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pix_count <= '0;
    else if (start_ok)
      pix_count <= '0;
    else if (accept && ({1'b0, pix_count} < PIX_TOTAL))
      pix_count <= pix_count + ADDR_W'(1);
  end

  assign load_cur  = (state == ST_F_CUR);
  assign load_w    = (state == ST_F_W);
  assign load_n    = (state == ST_F_N);
  assign err_valid = (state == ST_EMIT);
  assign pred_sel  = (state == ST_EMIT) ? {!first_row, !first_col} : PRED_NONE;
  assign busy      = (state == ST_F_CUR) || (state == ST_F_W) ||
                     (state == ST_F_N)   || (state == ST_EMIT);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_raster_scan_sequencer.sv
// Directed bench for raster_scan_sequencer on a 4x3 image: traversal order,
// back-pressure, ignored start, mid-frame reset and restart from DONE.
module tb_raster_scan_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 19;
  localparam int NF = 29;
  localparam int NP = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          err_ready = 1'b1;
  logic [AW-1:0] rd_addr;
  logic          load_cur;
  logic          load_w;
  logic          load_n;
  logic [1:0]    pred_sel;
  logic          err_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] pix_count;

  int checks = 0;
  int errors = 0;

  // Fetch addresses in order, with the load kind (1=cur, 2=W, 4=N) per fetch.
  int exp_addr [NF] = '{0, 1,0, 2,1, 3,2, 4,0, 5,4,1, 6,5,2, 7,6,3,
                        8,4, 9,8,5, 10,9,6, 11,10,7};
  int exp_ld   [NF] = '{1, 1,2, 1,2, 1,2, 1,4, 1,2,4, 1,2,4, 1,2,4,
                        1,4, 1,2,4, 1,2,4, 1,2,4};
  int exp_pred [NP] = '{0, 1, 1, 1, 2, 3, 3, 3, 2, 3, 3, 3};

  raster_scan_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_addr   (rd_addr),
    .load_cur  (load_cur),
    .load_w    (load_w),
    .load_n    (load_n),
    .pred_sel  (pred_sel),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a frame and follows it cycle by cycle until DONE (bounded).
  // stall_pix/stall_n: hold err_ready low for stall_n cycles at that pixel index.
  // abort_fi: return as soon as that fetch index has been observed.
  task automatic run_frame(input int stall_pix, input int stall_n, input bit noisy_start,
                           input int abort_fi, output int cycles, output bit aborted);
    int fi;
    int pi;
    int stall_left;
    logic [AW-1:0] last_addr;
    fi = 0;
    pi = 0;
    stall_left = stall_n;
    aborted = 1'b0;
    cycles = -1;
    last_addr = '0;
    err_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("done_drop", done, 0);
    chk("pix_clear", pix_count, 0);
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        cycles = k;
        break;
      end
      chk("busy_in_frame", busy, 1);
      if (load_cur || load_w || load_n) begin
        chk("load_onehot", int'(load_cur) + int'(load_w) + int'(load_n), 1);
        chk("load_vs_valid", err_valid, 0);
        if (fi < NF) begin
          chk("rd_addr", rd_addr, exp_addr[fi]);
          chk("load_kind", {load_n, load_w, load_cur}, exp_ld[fi]);
        end else begin
          chk("fetch_count", fi, NF - 1);
        end
        last_addr = rd_addr;
        if (fi == abort_fi) begin
          aborted = 1'b1;
          start = 1'b0;
          return;
        end
        fi++;
      end else if (err_valid) begin
        chk("pred_sel", pred_sel, (pi < NP) ? exp_pred[pi] : 0);
        chk("pix_count_emit", pix_count, pi);
        chk("rd_addr_hold", rd_addr, last_addr);
        if (pi == stall_pix && stall_left > 0) begin
          err_ready = 1'b0;
          stall_left--;
        end else begin
          err_ready = 1'b1;
          pi++;
        end
      end else begin
        chk("active_state", 0, 1);
      end
      if (noisy_start) start = (k % 5 == 2);
      @(negedge clk);
    end
    start = 1'b0;
    err_ready = 1'b1;
    chk("done_reached", done, 1);
    chk("fetches_total", fi, NF);
  endtask

  initial begin
    int cyc;
    bit ab;

    #1;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_loads", {load_n, load_w, load_cur}, 0);
    chk("rst_pred", pred_sel, 0);
    chk("rst_valid", err_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix", pix_count, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Plain frame, err_ready held high.
    run_frame(-1, 0, 1'b0, -1, cyc, ab);
    chk("frame1_cycles", cyc, 41);
    chk("frame1_pix", pix_count, 12);
    chk("frame1_busy", busy, 0);
    chk("frame1_valid", err_valid, 0);

    // Restart from DONE with a 5-cycle stall at pixel (1,1).
    run_frame(5, 5, 1'b0, -1, cyc, ab);
    chk("stall_cycles", cyc, 46);
    chk("stall_pix", pix_count, 12);

    // start pulses during the frame are ignored.
    run_frame(-1, 0, 1'b1, -1, cyc, ab);
    chk("noisy_cycles", cyc, 41);
    chk("noisy_pix", pix_count, 12);
    repeat (3) @(negedge clk);
    chk("done_level", done, 1);

    // Reset in F_N of pixel (2,1).
    run_frame(-1, 0, 1'b0, 14, cyc, ab);
    chk("abort_reached", ab, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_addr", rd_addr, 0);
    chk("mid_rst_loads", {load_n, load_w, load_cur}, 0);
    chk("mid_rst_pred", pred_sel, 0);
    chk("mid_rst_valid", err_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pix", pix_count, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("post_rst_addr", rd_addr, 0);
    run_frame(-1, 0, 1'b0, -1, cyc, ab);
    chk("post_rst_cycles", cyc, 41);
    chk("post_rst_pix", pix_count, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
